// File: rtl/serial_frame_tx_pkg.sv
// Shared types and sizing helpers for the serial frame transmitter and any matching receiver.
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: load sets the count, en decrements it, and tc flags zero.
module bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  // The counter stops at zero, so an all-ones period cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (en && !tc)  cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: MSB-first, programmable bit period, fixed inter-frame gap.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             srl_out,
  output logic             frame,
  output logic             bit_strobe,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int GAP_W = cnt_width(GAP);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             srl_d, frame_d, strobe_d;
  logic             t_load, t_en, t_tc;
  logic [DIV_W-1:0] t_val;

  bit_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .tc       (t_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      div_q      <= '0;
      srl_out    <= 1'b0;
      frame      <= 1'b0;
      bit_strobe <= 1'b0;
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      bit_cnt    <= bit_cnt_d;
      gap_cnt    <= gap_cnt_d;
      div_q      <= div_d;
      srl_out    <= srl_d;
      frame      <= frame_d;
      bit_strobe <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state;
    sreg_d    = sreg;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    div_d     = div_q;
    srl_d     = srl_out;
    frame_d   = frame;
    strobe_d  = bit_strobe;
    t_load    = 1'b0;
    t_en      = 1'b0;
    // The live div only matters on the accept edge; later bits reuse the latched copy.
    t_val     = (state == ST_IDLE) ? div : div_q;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          sreg_d    = in_data;
          srl_d     = in_data[WIDTH-1];
          frame_d   = 1'b1;
          strobe_d  = 1'b1;
          bit_cnt_d = '0;
          div_d     = div;
          t_load    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!t_tc) begin
          t_en     = 1'b1;
          strobe_d = 1'b0;
        end else if (bit_cnt != LAST_BIT) begin
          sreg_d    = sreg << 1;
          srl_d     = sreg[WIDTH-2];
          bit_cnt_d = bit_cnt + 1'b1;
          t_load    = 1'b1;
          strobe_d  = 1'b1;
        end else begin
          frame_d  = 1'b0;
          srl_d    = 1'b0;
          strobe_d = 1'b0;
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_W'(GAP - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_d = ST_IDLE;
        else               gap_cnt_d = gap_cnt - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: an 8-bit/GAP=1 instance plus a 2-bit/4-bit-divider instance.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, srl_out, frame, bit_strobe, busy;
  logic [7:0] div, in_data;

  logic       rst2_n, in_valid2, in_ready2, srl2, frame2, strobe2, busy2;
  logic [3:0] div2;
  logic [1:0] in_data2;

  int n_checks = 0;
  int n_fail   = 0;

  serial_frame_tx #(.WIDTH(8), .DIV_W(8), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .div(div), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .srl_out(srl_out), .frame(frame), .bit_strobe(bit_strobe), .busy(busy)
  );

  serial_frame_tx #(.WIDTH(2), .DIV_W(4), .GAP(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .div(div2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .srl_out(srl2), .frame(frame2), .bit_strobe(strobe2), .busy(busy2)
  );

  task automatic wait_ready(input string tag);
    int k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_timeout: in_ready=%b want 1", tag, in_ready);
    end
  endtask

  // Offers one word; returns in cycle 0 of the frame it starts.
  task automatic send_word(input logic [7:0] data, input logic [7:0] d, input string tag);
    wait_ready(tag);
    in_data  = data;
    div      = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF; div = 8'd0;
    in_valid2 = 1'b0; in_data2 = 2'b00; div2 = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (srl_out !== 1'b0 || frame !== 1'b0 || bit_strobe !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: srl=%b frame=%b strobe=%b busy=%b ready=%b want 0 0 0 0 1",
               srl_out, frame, bit_strobe, busy, in_ready);
    end
    n_checks++;
    if (frame2 !== 1'b0 || busy2 !== 1'b0 || in_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state2: frame=%b busy=%b ready=%b want 0 0 1", frame2, busy2, in_ready2);
    end
    in_valid = 1'b0;
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_a5_div0();
    logic [7:0] exp = 8'hA5;
    send_word(exp, 8'd0, "a5");
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (srl_out !== exp[7-c] || frame !== 1'b1 || bit_strobe !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL a5_bit c=%0d: srl=%b frame=%b strobe=%b ready=%b want %b 1 1 0",
                 c, srl_out, frame, bit_strobe, in_ready, exp[7-c]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (frame !== 1'b0 || srl_out !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL a5_gap: frame=%b srl=%b ready=%b busy=%b want 0 0 0 1", frame, srl_out, in_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_idle: ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_81_div2();
    logic exp_srl, exp_stb;
    send_word(8'h81, 8'd2, "d81");
    for (int c = 0; c < 24; c++) begin
      exp_srl = (c < 3) || (c >= 21);
      exp_stb = (c % 3) == 0;
      n_checks++;
      if (srl_out !== exp_srl || frame !== 1'b1 || bit_strobe !== exp_stb) begin
        n_fail++;
        $display("FAIL d81_cycle c=%0d: srl=%b frame=%b strobe=%b want %b 1 %b",
                 c, srl_out, frame, bit_strobe, exp_srl, exp_stb);
      end
      @(negedge clk);
    end
    n_checks++;
    if (frame !== 1'b0) begin
      n_fail++;
      $display("FAIL d81_end: frame=%b want 0", frame);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w1 = 8'h3C;
    logic [7:0] w2 = 8'hC3;
    wait_ready("b2b");
    in_data = w1; div = 8'd0; in_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      if (c >= 1 && c < 6) in_data = 8'hFF;
      else if (c >= 6 && c < 10) in_data = w2;
      else if (c >= 10) in_data = 8'hFF;
      if (c == 10) in_valid = 1'b0;
      n_checks++;
      if (c < 8) begin
        if (srl_out !== w1[7-c] || frame !== 1'b1 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_first c=%0d: srl=%b frame=%b ready=%b want %b 1 0",
                   c, srl_out, frame, in_ready, w1[7-c]);
        end
      end else if (c == 8) begin
        if (frame !== 1'b0 || in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_gap: frame=%b ready=%b want 0 0", frame, in_ready);
        end
      end else if (c == 9) begin
        if (frame !== 1'b0 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_accept_cycle: frame=%b ready=%b want 0 1", frame, in_ready);
        end
      end else begin
        if (srl_out !== w2[17-c] || frame !== 1'b1 || bit_strobe !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_second c=%0d: srl=%b frame=%b strobe=%b want %b 1 1",
                   c, srl_out, frame, bit_strobe, w2[17-c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w = 8'h96;
    logic exp_srl, exp_stb;
    send_word(8'h5A, 8'd1, "rmid");
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (frame !== 1'b0 || srl_out !== 1'b0 || bit_strobe !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_reset: frame=%b srl=%b strobe=%b busy=%b ready=%b want 0 0 0 0 1",
               frame, srl_out, bit_strobe, busy, in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    send_word(w, 8'd1, "rmid2");
    for (int c = 0; c < 16; c++) begin
      exp_srl = w[7 - c/2];
      exp_stb = (c % 2) == 0;
      n_checks++;
      if (srl_out !== exp_srl || frame !== 1'b1 || bit_strobe !== exp_stb) begin
        n_fail++;
        $display("FAIL rmid_resend c=%0d: srl=%b frame=%b strobe=%b want %b 1 %b",
                 c, srl_out, frame, bit_strobe, exp_srl, exp_stb);
      end
      @(negedge clk);
    end
    n_checks++;
    if (frame !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_end: frame=%b want 0", frame);
    end
  endtask

  task automatic test_div_change();
    logic [7:0] w1 = 8'hF0;
    logic [7:0] w2 = 8'h0F;
    logic exp_srl, exp_stb;
    send_word(w1, 8'd1, "dchg");
    for (int c = 0; c < 17; c++) begin
      if (c == 3) div = 8'd5;
      exp_srl = (c < 16) ? w1[7 - c/2] : 1'b0;
      exp_stb = (c < 16) && ((c % 2) == 0);
      n_checks++;
      if (srl_out !== exp_srl || frame !== (c < 16) || bit_strobe !== exp_stb) begin
        n_fail++;
        $display("FAIL dchg_first c=%0d: srl=%b frame=%b strobe=%b want %b %b %b",
                 c, srl_out, frame, bit_strobe, exp_srl, (c < 16), exp_stb);
      end
      @(negedge clk);
    end
    send_word(w2, 8'd5, "dchg2");
    for (int c = 0; c < 49; c++) begin
      exp_srl = (c < 48) ? w2[7 - c/6] : 1'b0;
      exp_stb = (c < 48) && ((c % 6) == 0);
      n_checks++;
      if (srl_out !== exp_srl || frame !== (c < 48) || bit_strobe !== exp_stb) begin
        n_fail++;
        $display("FAIL dchg_second c=%0d: srl=%b frame=%b strobe=%b want %b %b %b",
                 c, srl_out, frame, bit_strobe, exp_srl, (c < 48), exp_stb);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_max();
    logic exp_srl, exp_stb;
    int k = 0;
    while (in_ready2 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    in_data2 = 2'b10; div2 = 4'hF; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    for (int c = 0; c < 33; c++) begin
      exp_srl = (c < 16);
      exp_stb = (c == 0) || (c == 16);
      n_checks++;
      if (srl2 !== exp_srl || frame2 !== (c < 32) || strobe2 !== exp_stb) begin
        n_fail++;
        $display("FAIL dmax c=%0d: srl=%b frame=%b strobe=%b want %b %b %b",
                 c, srl2, frame2, strobe2, exp_srl, (c < 32), exp_stb);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a5_div0();
    test_81_div2();
    test_back_to_back();
    test_reset_mid();
    test_div_change();
    test_div_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
